bs_word_serializer: RTL and testbench
=====================================

// Module: bs_word_serializer
// PURPOSE
//   Converts parallel W-bit words into the team's bit-serial stream format:
//   LSB first, one bit per clk, sync pulse high during bit 0 of each word.
//   Sits at the head of a bit-serial datapath and feeds its data/sync inputs.
//   A one-entry holding buffer plus the shift register allow back-to-back words.
// PARAMETERS
//   W    8  word length in bits (legal: W >= 2)
//   GAP  0  idle cycles forced between consecutive words (legal: 0..15)
// PORTS
//   clk       in   1  clock, all state on rising edge
//   reset     in   1  synchronous, active-high
//   in_valid  in   1  in_data valid
//   in_data   in   W  word to serialize, bit 0 sent first
//   in_ready  out  1  holding buffer empty; word accepted when in_valid & in_ready
//   sdata     out  1  serial data bit (registered)
//   ssync     out  1  high exactly during bit 0 of a word (registered)
//   slast     out  1  high exactly during bit W-1 of a word (registered)
//   busy      out  1  shifter in SHIFT or GAP, or buffer full
// BEHAVIOUR
//   - Reset: sdata=0, ssync=0, slast=0, busy=0, in_ready=1; state IDLE;
//     buffer and shifter cleared; a word buffered or mid-shift is dropped.
//   - in_ready = !buf_valid; no combinational path from in_valid to in_ready.
//   - Acceptance at edge E: buf <= in_data, buf_valid <= 1.
//   - States: IDLE, SHIFT, GAP; counter cnt sized to max(W, GAP).
//     IDLE : if buf_valid -> load shifter from buf, buf_valid<=0, cnt<=0,
//            drive bit 0 with ssync=1; go SHIFT. Else outputs 0.
//     SHIFT: each edge sends next bit, cnt++. Bit W-1 drives slast=1.
//            After bit W-1: GAP>0 -> GAP (cnt<=0); GAP=0 and buf_valid ->
//            load next word, its bit 0 (ssync=1) directly follows; else IDLE.
//     GAP  : outputs 0 for exactly GAP cycles, then as IDLE (load or go IDLE).
//   - Latency: word accepted at edge E while IDLE -> bit 0 visible after E+1,
//     bit i after E+1+i.
//   - Throughput: one word per W+GAP cycles with in_valid held high.
//   - Load and acceptance in the same edge: no (buffer full that cycle); the
//     buffer refills one cycle after load, always before the next load (W>=2).
//   - ssync and slast never high together (W>=2). sdata=0 when not in SHIFT.
//   - in_data sampled only on acceptance; later changes ignored.
// TESTING
//   1 W=8,GAP=0: accept 0xA5 in IDLE -> sdata 1,0,1,0,0,1,0,1 on 8 cycles
//     after 1-cycle latency; ssync on 1st bit only, slast on 8th; then 0s.
//   2 W=8,GAP=0: 0x01 then 0xFF, in_valid held -> 16 contiguous bits
//     1,0*7,1*8; ssync at bit cycles 0 and 8; no idle cycle between.
//   3 W=8,GAP=2: 3 words back-to-back -> exactly 2 zero cycles between
//     words; ssync period 10 cycles.
//   4 Backpressure: in_valid held, 4 words -> in_ready low while buffer
//     full; no word lost or duplicated; order preserved on sdata.
//   5 Reset at bit 3 of 0xFF with a second word buffered -> next cycle all
//     outputs 0, in_ready=1, busy=0; buffered word never appears.
//   6 W=2: alternate 0b10,0b01 continuously -> sdata 0,1,1,0 repeating;
//     ssync and slast alternate every cycle, never overlap.

Source files
------------

// File: rtl/bs_word_serializer.sv
// Parallel-to-bit-serial converter: LSB first, one bit per clock, with
// ssync marking bit 0 and slast marking bit W-1 of every word. A one-entry
// holding buffer in front of the shifter allows back-to-back words.
module bs_word_serializer #(
  parameter int unsigned W   = 8,
  parameter int unsigned GAP = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         sdata,
  output logic         ssync,
  output logic         slast,
  output logic         busy
);

  localparam int unsigned CMAX = (W > GAP) ? W : GAP;
  localparam int unsigned CW   = $clog2(CMAX);
  localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'((GAP == 0) ? 0 : GAP - 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic [W-1:0]  shreg, shreg_n;
  logic [W-1:0]  buf_data;
  logic          buf_valid;
  logic          sdata_n, ssync_n, slast_n;
  logic          load;
  logic          accept;

  assign in_ready = !buf_valid;
  assign accept   = in_valid && in_ready;
  assign busy     = (state != S_IDLE) || buf_valid;
  assign cnt_inc  = cnt + CW'(1);

  // Holding buffer: filled on handshake, emptied when the shifter loads it.
  // A load requires a full buffer, so both can never happen on one edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_valid <= 1'b0;
      buf_data  <= '0;
    end else if (accept) begin
      buf_valid <= 1'b1;
      buf_data  <= in_data;
    end else if (load) begin
      buf_valid <= 1'b0;
    end
  end

  // State, counter, shifter and registered serial outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      shreg <= '0;
      sdata <= 1'b0;
      ssync <= 1'b0;
      slast <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      shreg <= shreg_n;
      sdata <= sdata_n;
      ssync <= ssync_n;
      slast <= slast_n;
    end
  end

  // Next-state and next-output logic. The shifter holds the bits still to
  // be sent after the one currently on sdata, so bit 0 goes out straight
  // from the buffer on load.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    shreg_n = shreg;
    sdata_n = 1'b0;
    ssync_n = 1'b0;
    slast_n = 1'b0;
    load    = 1'b0;
    unique case (state)
      S_SHIFT: begin
        if (cnt == LAST_BIT) begin
          if (GAP > 0) begin
            state_n = S_GAP;
            cnt_n   = '0;
          end else if (buf_valid) begin
            load    = 1'b1;
            state_n = S_SHIFT;
            cnt_n   = '0;
            shreg_n = {1'b0, buf_data[W-1:1]};
            sdata_n = buf_data[0];
            ssync_n = 1'b1;
          end else begin
            state_n = S_IDLE;
          end
        end else begin
          cnt_n   = cnt_inc;
          shreg_n = {1'b0, shreg[W-1:1]};
          sdata_n = shreg[0];
          slast_n = (cnt_inc == LAST_BIT);
        end
      end
      S_GAP: begin
        if (cnt == GAP_LAST) begin
          if (buf_valid) begin
            load    = 1'b1;
            state_n = S_SHIFT;
            cnt_n   = '0;
            shreg_n = {1'b0, buf_data[W-1:1]};
            sdata_n = buf_data[0];
            ssync_n = 1'b1;
          end else begin
            state_n = S_IDLE;
          end
        end else begin
          cnt_n = cnt_inc;
        end
      end
      default: begin
        if (buf_valid) begin
          load    = 1'b1;
          state_n = S_SHIFT;
          cnt_n   = '0;
          shreg_n = {1'b0, buf_data[W-1:1]};
          sdata_n = buf_data[0];
          ssync_n = 1'b1;
        end else begin
          state_n = S_IDLE;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_bs_word_serializer.sv
// Directed bench for bs_word_serializer: three instances (W=8/GAP=0,
// W=8/GAP=2, W=2/GAP=0) share one stimulus port selected by 'sel'.
module tb_bs_word_serializer;

  logic       clk = 1'b0;
  logic       reset;
  logic       tv;
  logic [7:0] td;
  int         sel;

  logic v8, vg, v2;
  logic rdy8, rdyg, rdy2;
  logic sd8, sdg, sd2, ss8, ssg, ss2, sl8, slg, sl2, bz8, bzg, bz2;
  logic cur_ready, cur_sdata, cur_ssync, cur_slast, cur_busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign v8 = tv && (sel == 0);
  assign vg = tv && (sel == 1);
  assign v2 = tv && (sel == 2);

  bs_word_serializer #(.W(8), .GAP(0)) u8 (
    .clk(clk), .reset(reset), .in_valid(v8), .in_data(td), .in_ready(rdy8),
    .sdata(sd8), .ssync(ss8), .slast(sl8), .busy(bz8));

  bs_word_serializer #(.W(8), .GAP(2)) ug (
    .clk(clk), .reset(reset), .in_valid(vg), .in_data(td), .in_ready(rdyg),
    .sdata(sdg), .ssync(ssg), .slast(slg), .busy(bzg));

  bs_word_serializer #(.W(2), .GAP(0)) u2 (
    .clk(clk), .reset(reset), .in_valid(v2), .in_data(td[1:0]), .in_ready(rdy2),
    .sdata(sd2), .ssync(ss2), .slast(sl2), .busy(bz2));

  // Route the selected instance's outputs to a common set of probes.
  always_comb begin
    cur_ready = rdy8; cur_sdata = sd8; cur_ssync = ss8; cur_slast = sl8; cur_busy = bz8;
    if (sel == 1) begin
      cur_ready = rdyg; cur_sdata = sdg; cur_ssync = ssg; cur_slast = slg; cur_busy = bzg;
    end else if (sel == 2) begin
      cur_ready = rdy2; cur_sdata = sd2; cur_ssync = ss2; cur_slast = sl2; cur_busy = bz2;
    end
  end

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       e_sdata;
    logic       e_ssync;
    logic       e_slast;
    logic       e_ready;
    logic       e_busy;
  } vec_t;

  vec_t       vecs[11];
  logic [7:0] wq[8];
  logic [2:0] exp_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Feed wq[0..nw-1] with in_valid held while words remain; compare the
  // serial stream from the first ssync onward against the expected stream.
  task automatic run_words(input int s, input int w, input int gap, input int nw,
                           input int exp_stalls, input string tag);
    int acc = 0;
    int pos = 0;
    int stalls = 0;
    bit started = 0;
    bit fire;
    sel = s;
    exp_q.delete();
    for (int k = 0; k < nw; k++) begin
      for (int b = 0; b < w; b++)
        exp_q.push_back({wq[k][b], (b == 0) ? 1'b1 : 1'b0, (b == w - 1) ? 1'b1 : 1'b0});
      if (k < nw - 1)
        for (int g = 0; g < gap; g++) exp_q.push_back(3'b000);
    end
    for (int cyc = 0; cyc < 300 && pos < exp_q.size(); cyc++) begin
      tv = (acc < nw);
      td = (acc < nw) ? wq[acc] : 8'h00;
      #1;
      fire = tv && cur_ready;
      if (tv && !cur_ready) stalls++;
      tick();
      if (fire) acc++;
      if (!started && cur_ssync) started = 1;
      if (started && pos < exp_q.size()) begin
        check($sformatf("%s bit%0d {d,sync,last}", tag, pos),
              {29'd0, cur_sdata, cur_ssync, cur_slast}, {29'd0, exp_q[pos]});
        pos++;
      end
    end
    tv = 1'b0;
    check({tag, " stream length"}, pos, exp_q.size());
    check({tag, " words accepted"}, acc, nw);
    check({tag, " stall cycles"}, stalls, exp_stalls);
    repeat (gap + 1) tick();
    check({tag, " idle after stream {d,sync,last,busy}"},
          {cur_sdata, cur_ssync, cur_slast, cur_busy}, 4'b0000);
  endtask

  initial begin
    int activity;
    // Test 1 table: accept 0xA5 then watch the 8 bits and the return to idle.
    vecs[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    sel = 0; tv = 1'b0; td = 8'h00; reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    check("reset u8 {d,sync,last,ready,busy}", {sd8, ss8, sl8, rdy8, bz8}, 5'b00010);
    check("reset ug {d,sync,last,ready,busy}", {sdg, ssg, slg, rdyg, bzg}, 5'b00010);
    check("reset u2 {d,sync,last,ready,busy}", {sd2, ss2, sl2, rdy2, bz2}, 5'b00010);

    for (int i = 0; i < 11; i++) begin
      tv = vecs[i].v;
      td = vecs[i].d;
      tick();
      check($sformatf("vec%0d {d,sync,last,ready,busy}", i),
            {cur_sdata, cur_ssync, cur_slast, cur_ready, cur_busy},
            {vecs[i].e_sdata, vecs[i].e_ssync, vecs[i].e_slast, vecs[i].e_ready, vecs[i].e_busy});
    end

    // Test 2: two words back-to-back, no idle cycle between them.
    wq[0] = 8'h01; wq[1] = 8'hFF;
    run_words(0, 8, 0, 2, 1, "b2b");

    // Test 3: GAP=2, three words, two zero cycles between words.
    wq[0] = 8'h81; wq[1] = 8'h7E; wq[2] = 8'hC3;
    run_words(1, 8, 2, 3, 1 + 1 * (8 + 2 - 1), "gap2");

    // Test 4: backpressure with four words, order and count preserved.
    wq[0] = 8'h12; wq[1] = 8'h34; wq[2] = 8'h56; wq[3] = 8'h78;
    run_words(0, 8, 0, 4, 1 + 2 * (8 + 0 - 1), "bp");

    // Test 6: W=2 alternating 0b10 / 0b01.
    for (int k = 0; k < 6; k++) wq[k] = (k % 2 == 0) ? 8'h02 : 8'h01;
    run_words(2, 2, 0, 6, 1 + 4 * (2 + 0 - 1), "w2");

    // Test 5: reset while bit 3 of 0xFF is on the line and 0x3C is buffered.
    sel = 0;
    tv = 1'b1; td = 8'hFF;
    tick();                      // 0xFF accepted
    td = 8'h3C;
    tick();                      // buffer full: load 0xFF, bit 0 out
    check("rst seq bit0 {d,sync}", {cur_sdata, cur_ssync}, 2'b11);
    tick();                      // 0x3C accepted, bit 1 out
    tv = 1'b0;
    tick();                      // bit 2
    tick();                      // bit 3
    check("rst seq bit3 {d,sync,last,ready}", {cur_sdata, cur_ssync, cur_slast, cur_ready}, 4'b1000);
    reset = 1'b1;
    tick();
    check("after reset {d,sync,last,ready,busy}",
          {cur_sdata, cur_ssync, cur_slast, cur_ready, cur_busy}, 5'b00010);
    reset = 1'b0;
    activity = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (cur_sdata || cur_ssync || cur_slast || cur_busy) activity++;
    end
    check("dropped word stays dropped (active cycles)", activity, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
